// File: rtl/ram_stream_pkg.sv
// Shared types and width helpers for the RAM read streamer.
package ram_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // A depth of 1 would give a zero-width address, so floor it at one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_w(input int depth);
    return addr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Loadable modulo-depth_p up-counter; wraps from depth_p-1 back to 0.
module wrap_counter
  import ram_stream_pkg::*;
#(
  parameter int depth_p = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        load_i,
  input  logic [addr_w(depth_p)-1:0]  load_val_i,
  input  logic                        en_i,
  output logic [addr_w(depth_p)-1:0]  count_o
);

  localparam int AW = addr_w(depth_p);
  localparam logic [AW-1:0] LastC = AW'(depth_p - 1);

  logic [AW-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= {AW{1'b0}};
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i) begin
      count_q <= (count_q == LastC) ? {AW{1'b0}} : count_q + AW'(1);
    end else begin
      count_q <= count_q;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Streams count_i words from an async-read RAM onto a registered ready/valid port.
// Optional in-order check enabled by defining RAM_STREAM_SORT_CHECK_EN.
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int width_p = 8,
  parameter int depth_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  input  logic [addr_w(depth_p)-1:0]   base_addr_i,
  input  logic [count_w(depth_p)-1:0]  count_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [addr_w(depth_p)-1:0]   rd_addr_o,
  input  logic [width_p-1:0]           rd_data_i,
  output logic                         valid_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         ready_i,
  output logic                         sorted_err_o
);

  localparam int CW = count_w(depth_p);

  state_e              state_q;
  logic [CW-1:0]       remaining_q;
  logic                valid_q;
  logic [width_p-1:0]  data_q;
  logic                busy_q;
  logic                done_q;

  logic accept_s;
  logic load_s;
  logic hs_s;

  assign accept_s = (state_q == ST_IDLE) && start_i;
  assign hs_s     = valid_q && ready_i;
  assign load_s   = (state_q == ST_STREAM) && (remaining_q != {CW{1'b0}})
                    && (!valid_q || ready_i);

  wrap_counter #(.depth_p(depth_p)) u_addr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (accept_s && (count_i != {CW{1'b0}})),
    .load_val_i (base_addr_i),
    .en_i       (load_s),
    .count_o    (rd_addr_o)
  );

  // Transfer FSM with registered status and data outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      remaining_q <= {CW{1'b0}};
      valid_q     <= 1'b0;
      data_q      <= {width_p{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i && (count_i != {CW{1'b0}})) begin
            remaining_q <= count_i;
            busy_q      <= 1'b1;
            state_q     <= ST_STREAM;
          end else if (start_i) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_STREAM: begin
          if (load_s) begin
            data_q      <= rd_data_i;
            valid_q     <= 1'b1;
            remaining_q <= remaining_q - CW'(1);
            if (remaining_q == CW'(1)) begin
              state_q <= ST_DRAIN;
            end else begin
              state_q <= ST_STREAM;
            end
          end else if (hs_s) begin
            valid_q <= 1'b0;
          end else begin
            valid_q <= valid_q;
          end
        end
        ST_DRAIN: begin
          if (hs_s) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;

`ifdef RAM_STREAM_SORT_CHECK_EN
  logic [width_p-1:0] prev_q;
  logic               have_prev_q;
  logic               err_q;

  // Sticky order check across accepted words of one transfer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q      <= {width_p{1'b0}};
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (accept_s) begin
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (hs_s) begin
      if (have_prev_q && (data_q < prev_q)) begin
        err_q <= 1'b1;
      end else begin
        err_q <= err_q;
      end
      prev_q      <= data_q;
      have_prev_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end

  assign sorted_err_o = err_q;
`else
  assign sorted_err_o = 1'b0;
`endif

endmodule
